// File: rtl/rv32i_types.sv
// Shared RV32/RV64 execute-stage types: M-extension funct3 encoding and the
// iterative multiply/divide unit state encoding.
package rv32i_types;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      mul    = 3'b000,
      mulh   = 3'b001,
      mulhsu = 3'b010,
      mulhu  = 3'b011,
      div    = 3'b100,
      divu   = 3'b101,
      rem    = 3'b110,
      remu   = 3'b111
   } m_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: subtract the divisor from the shifted-in
// partial remainder when it fits, producing one quotient bit.
module muldiv_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   part_rem,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic            q_bit
);

   // The remainder is always below the divisor, so the difference fits in XLEN bits.
   always_comb begin
      q_bit    = (part_rem >= {1'b0, divisor});
      rem_next = q_bit ? (part_rem[XLEN-1:0] - divisor) : part_rem[XLEN-1:0];
   end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshake and flush.
// Works on operand magnitudes and applies the recorded result sign at the end.
module muldiv_iter_unit
   import rv32i_types::*;
#(
   parameter int XLEN               = XLEN_DEFAULT,
   parameter int MUL_BITS_PER_CYCLE = 2,
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  m_funct3_t       funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            busy
);

   localparam int MB      = MUL_BITS_PER_CYCLE;
   localparam int DB      = DIV_BITS_PER_CYCLE;
   localparam int MUL_CNT = XLEN / MB;
   localparam int DIV_CNT = XLEN / DB;
   localparam int CNT_W   = $clog2(XLEN + 1);
   localparam int PW      = XLEN + MB;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("XLEN must be 32 or 64");
   end
   if ((MB & (MB - 1)) != 0 || MB < 1 || MB > XLEN / 2 || (XLEN % MB) != 0) begin : g_bad_mul
      $error("MUL_BITS_PER_CYCLE must be a power of two dividing XLEN");
   end
   if ((DB != 1 && DB != 2) || (XLEN % DB) != 0) begin : g_bad_div
      $error("DIV_BITS_PER_CYCLE must be 1 or 2 and divide XLEN");
   end

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   muldiv_state_t state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opd_r;
   m_funct3_t         op_r;
   logic              a_neg_r, b_neg_r;
   logic              accept, last_step;

   logic signed [XLEN-1:0] rs1_s, rs2_s;
   logic            rs1_signed, rs2_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag, special_res;
   logic            div_zero, div_ovf, special;

   always_comb begin
      rs1_s      = signed'(rs1_data);
      rs2_s      = signed'(rs2_data);
      rs1_signed = funct3 inside {mulh, mulhsu, div, rem};
      rs2_signed = funct3 inside {mulh, div, rem};
      a_neg      = rs1_signed && (rs1_s < 0);
      b_neg      = rs2_signed && (rs2_s < 0);
      a_mag      = neg_if(rs1_data, a_neg);
      b_mag      = neg_if(rs2_data, b_neg);
      div_zero   = (rs2_data == '0);
      div_ovf    = (funct3 inside {div, rem}) && (rs1_data == INT_MIN) && (rs2_data == '1);
      special    = funct3[2] && (div_zero || div_ovf);
      if (funct3[1])
         special_res = div_zero ? rs1_data : '0;
      else
         special_res = div_zero ? '1 : rs1_data;
   end

   // Multiply: add one radix-2^MB digit times the multiplicand, shift right by MB.
   logic [MB-1:0]     mul_digit;
   logic [PW-1:0]     mul_sum;
   logic [2*XLEN-1:0] acc_mul_next, mul_prod;
   logic [XLEN-1:0]   mul_res;

   always_comb begin
      mul_digit    = acc[MB-1:0];
      mul_sum      = PW'(acc[2*XLEN-1:XLEN]) + PW'(opd_r) * PW'(mul_digit);
      acc_mul_next = {mul_sum, acc[XLEN-1:MB]};
      mul_prod     = neg_if_wide(acc_mul_next, a_neg_r ^ b_neg_r);
      mul_res      = (op_r == mul) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
   end

   // Divide: acc holds {remainder, dividend/quotient}; DB chained restoring steps.
   logic [XLEN-1:0]   div_rem [DB+1];
   logic [DB-1:0]     div_qbits;
   logic [2*XLEN-1:0] acc_div_next;
   logic [XLEN-1:0]   div_res;

   assign div_rem[0] = acc[2*XLEN-1:XLEN];

   for (genvar i = 0; i < DB; i++) begin : g_div_chain
      muldiv_div_step #(.XLEN(XLEN)) u_step (
         .part_rem ({div_rem[i], acc[XLEN-1-i]}),
         .divisor  (opd_r),
         .rem_next (div_rem[i+1]),
         .q_bit    (div_qbits[DB-1-i])
      );
   end

   always_comb begin
      acc_div_next = {div_rem[DB], acc[XLEN-DB-1:0], div_qbits};
      if (op_r[1])
         div_res = neg_if(div_rem[DB], a_neg_r);
      else
         div_res = neg_if(acc_div_next[XLEN-1:0], a_neg_r ^ b_neg_r);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      busy       = (state != IDLE);
      last_step  = (cnt == CNT_W'(1));
      case (state)
         IDLE: req_ready = 1'b1;
         MUL:  if (last_step) state_next = DONE;
         DIV:  if (last_step) state_next = DONE;
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               req_ready  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) req_ready = 1'b0;
      accept = req_ready && req_valid;
      if (accept)
         state_next = !funct3[2] ? MUL : (special ? DONE : DIV);
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         opd_r     <= '0;
         op_r      <= mul;
         a_neg_r   <= 1'b0;
         b_neg_r   <= 1'b0;
         resp_data <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept) begin
         op_r    <= funct3;
         a_neg_r <= a_neg;
         b_neg_r <= b_neg;
         if (!funct3[2]) begin
            cnt   <= CNT_W'(MUL_CNT);
            acc   <= {{XLEN{1'b0}}, b_mag};
            opd_r <= a_mag;
         end else begin
            cnt   <= special ? '0 : CNT_W'(DIV_CNT);
            acc   <= {{XLEN{1'b0}}, a_mag};
            opd_r <= b_mag;
            if (special) resp_data <= special_res;
         end
      end else if (state == MUL) begin
         acc <= acc_mul_next;
         cnt <= cnt - CNT_W'(1);
         if (last_step) resp_data <= mul_res;
      end else if (state == DIV) begin
         acc <= acc_div_next;
         cnt <= cnt - CNT_W'(1);
         if (last_step) resp_data <= div_res;
      end
   end

endmodule

// File: doc/muldiv_iter_unit.md
# muldiv_iter_unit

Parametrised, iterative RV32M/RV64M multiply/divide unit for the execute stage. It replaces the fixed-width, done-only M-extension ALU. Multiply and divide throughput are set by separate parameters. Operands and results move through a valid/ready handshake, and a flush input kills in-flight work when a branch resolves as taken. The execute stage derives its stall from `busy`/`resp_valid` and muxes `resp_data` into `alu_out` for M-extension instructions.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; 32 or 64.
- `MUL_BITS_PER_CYCLE`, 2: multiplier bits retired per cycle; power of two, must divide `XLEN`.
- `DIV_BITS_PER_CYCLE`, 1: quotient bits produced per cycle; 1 or 2, must divide `XLEN`.

Ports:
- `clk` in 1: clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: operation request.
- `req_ready` out 1: unit can accept a request this cycle.
- `funct3` in 3: `m_funct3_t` (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
- `rs1_data` in XLEN: forwarded rs1 operand.
- `rs2_data` in XLEN: forwarded rs2 operand.
- `flush` in 1: abort any in-flight or pending operation.
- `resp_valid` out 1: result valid.
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out XLEN: result.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: `req_ready`=1. When `req_valid` is high, the unit captures the operands and funct3.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 with a special divide case goes straight to DONE.
  - Otherwise it goes to DIV.
- Operand signs: the unit converts operands to magnitudes.
  - rs1 is signed for mulh, mulhsu, div and rem.
  - rs2 is signed for mulh, div and rem.
  - The result sign is recorded at capture.
- MUL: radix-2^`MUL_BITS_PER_CYCLE` shift-add into a 2·XLEN accumulator. The counter starts at `XLEN/MUL_BITS_PER_CYCLE` and decrements each cycle; at 0 the FSM goes to DONE.
  - The 2·XLEN product is negated when the recorded sign is negative.
  - mul returns the low XLEN bits; mulh, mulhsu and mulhu return the high XLEN bits.
- DIV: restoring division producing `DIV_BITS_PER_CYCLE` quotient bits per cycle, over `XLEN/DIV_BITS_PER_CYCLE` cycles.
  - The quotient takes the sign of rs1 XOR rs2; the remainder takes the sign of rs1.
- Special divide cases (no iteration):
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, div/rem only): quotient = rs1; remainder = 0.
- DONE: `resp_valid`=1 and `resp_data` is held stable until `resp_ready`=1.
  - On the handoff cycle `req_ready`=1, so a new request is accepted back-to-back.
  - After handoff the FSM goes to IDLE, or to the new operation's start state if a request was accepted.
- `flush` has priority over everything. On the next edge the FSM is in IDLE, the counter is cleared and `resp_valid`=0.
  - A request presented in the same cycle as `flush` is not accepted.
  - `req_ready` is forced to 0 while `flush`=1.
- Reset values: state=IDLE, `resp_valid`=0, `resp_data`=0, `busy`=0, `req_ready`=1 (after reset), counters and accumulators 0.
- Reset mid-operation: identical to flush; no partial result ever appears.

## Timing
- Accept edge = cycle 0.
- Multiply: `resp_valid` rises at cycle `XLEN/MUL_BITS_PER_CYCLE`+1, i.e. 17 cycles for XLEN=32 with 2 bits/cycle.
- Divide: `resp_valid` rises at cycle `XLEN/DIV_BITS_PER_CYCLE`+1, i.e. 33 cycles for XLEN=32 with 1 bit/cycle.
- Special divide cases: `resp_valid` rises at cycle 1.
- `busy`=1 from cycle 1 until the edge after handoff.
- `resp_data` is registered, with no combinational path from inputs.
- Operands are sampled only on the accept edge, so later changes on `rs1_data`/`rs2_data` have no effect.

## Structure
- Shared `rv32i_types` package gains:
  - `muldiv_state_t` enum: IDLE, MUL, DIV, DONE.
  - `XLEN` default constant.
  - `m_funct3_t` reused unchanged.
- Sub-module `muldiv_div_step`: combinational, one restoring step (partial remainder, divisor → next remainder, quotient bit). It is instantiated `DIV_BITS_PER_CYCLE` times in a chain.
- Elaboration-time assertions check both divisibility constraints.

## Test plan
- mul, rs1=7, rs2=0xFFFFFFFD (-3) → `resp_data`=0xFFFFFFEB at cycle 17; `busy` high during cycles 1–17.
- mulh, 0x80000000 × 0x80000000 → 0x40000000; mulhu, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; mulhsu, 0xFFFFFFFF (-1) × 2 → 0xFFFFFFFF.
- div, -7/2 → 0xFFFFFFFD; rem, -7/2 → 0xFFFFFFFF; divu, 100/7 → 14; remu, 100/7 → 2; each result at cycle 33.
- Special divide cases, each result at cycle 1:
  - divu 5/0 → 0xFFFFFFFF; rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000; rem of the same operands → 0.
- Flush at cycle 5 of a div → IDLE at cycle 6 with `resp_valid` never asserted. A `req_valid` held during the flush cycle is ignored and accepted on the following cycle.
- Hold `resp_ready`=0 for 4 cycles after DONE → `resp_data` stable, `resp_valid` high throughout. Then `resp_ready`=1 with a new mul request → accepted the same cycle, next result 17 cycles later.
- Rerun the mul and div vectors with XLEN=64, MUL_BITS_PER_CYCLE=4, DIV_BITS_PER_CYCLE=2 → same results (sign-extended), multiply latency 17, divide latency 33.
